// File: rtl/kb_scancode_queue.sv
// rtl/kb_scancode_queue.sv - scancode FIFO with paced one-byte-per-pulse release to the chipset.
// Optional typematic auto-repeat injection is enabled by defining KB_TYPEMATIC_EN.
module kb_scancode_queue #(
  parameter int DEPTH            = 16,
  parameter int GAP_CYCLES       = 50000,
  parameter int TYPEMATIC_DELAY  = 25000000,
  parameter int TYPEMATIC_PERIOD = 5000000
) (
  input  logic                     clk_chipset,
  input  logic                     reset_n,
  input  logic [7:0]               mcu_data,
  input  logic                     mcu_valid,
  input  logic                     flush,
  output logic [7:0]               kb_scancode,
  output logic                     kb_scancode_upd,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GAP  = 1'b1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [0:0]    r_state;
  logic [CW-1:0] r_gap_cnt;
  logic [7:0]    r_scancode;
  logic          r_upd;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_mcu_push;
  logic [1:0]    w_push_cnt;
  logic [7:0]    w_push_b0;
  logic [7:0]    w_push_b1;

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_mcu_push = reset_n && !flush && mcu_valid && !w_full;

`ifdef KB_TYPEMATIC_EN
  localparam int TMAX = (TYPEMATIC_DELAY > TYPEMATIC_PERIOD) ? TYPEMATIC_DELAY : TYPEMATIC_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  logic          r_tm_armed;
  logic          r_tm_prefix;
  logic          r_tm_key_pre;
  logic [6:0]    r_tm_key;
  logic [2:0]    r_tm_skip;
  logic [TW-1:0] r_tm_timer;
  logic          w_tm_expire;
  logic          w_tm_fit;

  // An MCU strobe on the expiry cycle holds the timer at 1, deferring the repeat by a cycle.
  assign w_tm_expire = reset_n && !flush && r_tm_armed && (r_tm_timer <= TW'(1)) && !mcu_valid;
  assign w_tm_fit    = (LW'(DEPTH) - r_level) >= (r_tm_key_pre ? LW'(2) : LW'(1));

  always_ff @(posedge clk_chipset) begin
    if (!reset_n || flush) begin
      r_tm_armed   <= 1'b0;
      r_tm_prefix  <= 1'b0;
      r_tm_key_pre <= 1'b0;
      r_tm_key     <= 7'h00;
      r_tm_skip    <= 3'd0;
      r_tm_timer   <= '0;
    end else begin
      if (w_tm_expire) begin
        r_tm_timer <= TW'(TYPEMATIC_PERIOD);
      end else if (r_tm_timer > TW'(1)) begin
        r_tm_timer <= r_tm_timer - TW'(1);
      end
      if (w_mcu_push) begin
        if (r_tm_skip != 3'd0) begin
          r_tm_skip <= r_tm_skip - 3'd1;
        end else if (mcu_data == 8'hE0) begin
          r_tm_prefix <= 1'b1;
        end else if (mcu_data == 8'hE1) begin
          r_tm_armed  <= 1'b0;
          r_tm_skip   <= 3'd5;
          r_tm_prefix <= 1'b0;
        end else if (!mcu_data[7]) begin
          r_tm_key     <= mcu_data[6:0];
          r_tm_key_pre <= r_tm_prefix;
          r_tm_armed   <= 1'b1;
          r_tm_timer   <= TW'(TYPEMATIC_DELAY);
          r_tm_prefix  <= 1'b0;
        end else begin
          if ((mcu_data[6:0] == r_tm_key) && (r_tm_prefix == r_tm_key_pre)) begin
            r_tm_armed <= 1'b0;
          end
          r_tm_prefix <= 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_tm;
  assign w_unused_tm = (TYPEMATIC_DELAY != 0) ^ (TYPEMATIC_PERIOD != 0);
`endif

  always_comb begin
    w_push_cnt = 2'd0;
    w_push_b0  = mcu_data;
    w_push_b1  = 8'h00;
    if (w_mcu_push) begin
      w_push_cnt = 2'd1;
    end
`ifdef KB_TYPEMATIC_EN
    else if (w_tm_expire && w_tm_fit) begin
      if (r_tm_key_pre) begin
        w_push_cnt = 2'd2;
        w_push_b0  = 8'hE0;
        w_push_b1  = {1'b0, r_tm_key};
      end else begin
        w_push_cnt = 2'd1;
        w_push_b0  = {1'b0, r_tm_key};
      end
    end
`endif
  end

  always_ff @(posedge clk_chipset) begin
    if (w_push_cnt != 2'd0) begin
      r_mem[r_wr_ptr] <= w_push_b0;
    end
    if (w_push_cnt == 2'd2) begin
      r_mem[r_wr_ptr + AW'(1)] <= w_push_b1;
    end
  end

  always_ff @(posedge clk_chipset) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_scancode <= 8'h00;
      r_upd      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_upd      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_level  <= r_level + LW'(w_push_cnt) - LW'(w_pop);
      r_upd    <= 1'b0;
      if (mcu_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_scancode <= r_mem[r_rd_ptr];
            r_upd      <= 1'b1;
            r_state    <= S_GAP;
            r_gap_cnt  <= CW'(GAP_CYCLES);
          end
        end
        default: begin
          // Leaving on the 1->0 step lets the next pulse land exactly GAP_CYCLES+1 edges later.
          if (r_gap_cnt <= CW'(1)) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign kb_scancode     = r_scancode;
  assign kb_scancode_upd = r_upd;
  assign fifo_level      = r_level;
  assign overflow        = r_overflow;
endmodule
